// File: rtl/mem_responder.sv
// Word-addressed memory responder with programmable wait states for the multicycle core.
// Optional feature: define MEM_ADDR_CHECK_EN to flag out-of-range addresses via ERR.
module mem_responder #(
  parameter int unsigned DW          = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          MEM_OE,
  input  logic          MEM_WS,
  input  logic [31:0]   ADDR,
  input  logic [DW-1:0] DIN,
  output logic [DW-1:0] DOUT,
  output logic          RDY,
  output logic          BUSY,
  output logic          ERR
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDone = 2'd2;
  localparam logic [1:0] StHold = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          we_q, we_d;
  logic          bad_q, bad_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          rdy_q, rdy_d;
  logic          err_q, err_d;
  logic          mem_we;
  logic          addr_bad;

  logic [DW-1:0] mem [DEPTH];

`ifdef MEM_ADDR_CHECK_EN
  assign addr_bad = (ADDR >= 32'(DEPTH));
`else
  // Without the check the upper address bits simply wrap away.
  logic unused_addr_hi;
  assign unused_addr_hi = ^ADDR[31:AW];
  assign addr_bad       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = we_q;
    bad_d   = bad_q;
    dout_d  = dout_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (MEM_OE || MEM_WS) begin
          addr_d  = ADDR[AW-1:0];
          din_d   = DIN;
          we_d    = MEM_WS;
          bad_d   = addr_bad;
          cnt_d   = CW'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? StWait : StDone;
        end
      end
      StWait: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        rdy_d = 1'b1;
        err_d = bad_q;
        if (we_q) begin
          mem_we = ~bad_q & ~RST;
        end else begin
          dout_d = bad_q ? '0 : mem[addr_q];
        end
        state_d = StHold;
      end
      StHold: begin
        // Wait for strobes to drop so a held strobe cannot replay the access.
        if (!MEM_OE && !MEM_WS) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      bad_q   <= 1'b0;
      dout_q  <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      bad_q   <= bad_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately not reset; contents survive RST.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[addr_q] <= din_q;
    end
  end

  assign DOUT = dout_q;
  assign RDY  = rdy_q;
  assign ERR  = err_q;
  assign BUSY = (state_q == StWait) || (state_q == StDone);

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder, two instances (2 and 0 wait states).
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        oe, ws, oe0, ws0;
  logic [31:0] addr, din;
  logic [31:0] dout, dout0;
  logic        rdy, busy, err, rdy0, busy0, err0;

  int checks = 0;
  int errors = 0;

  mem_responder #(.DW(32), .DEPTH(256), .WAIT_STATES(2)) u_dut (
    .CLK(clk), .RST(rst), .MEM_OE(oe), .MEM_WS(ws), .ADDR(addr), .DIN(din),
    .DOUT(dout), .RDY(rdy), .BUSY(busy), .ERR(err)
  );

  mem_responder #(.DW(32), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .CLK(clk), .RST(rst), .MEM_OE(oe0), .MEM_WS(ws0), .ADDR(addr), .DIN(din),
    .DOUT(dout0), .RDY(rdy0), .BUSY(busy0), .ERR(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on the 2-wait-state instance; returns edges from acceptance to RDY.
  task automatic access(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output int busy_n,
                        output logic [31:0] rd, output logic e);
    ws = w; oe = r; addr = a; din = d;
    lat = 99; busy_n = 0; rd = '0; e = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (busy) busy_n++;
      if (rdy) begin
        lat = k - 1; rd = dout; e = err;
        break;
      end
    end
    ws = 1'b0; oe = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  int          lat, bn, n, first, rdy_seen;
  logic [31:0] rd;
  logic        e;

  initial begin
    rst = 1'b1; oe = 0; ws = 0; oe0 = 0; ws0 = 0; addr = '0; din = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dout", dout, 32'h0);
    check("rst_rdy", 32'(rdy), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    rst = 1'b0;

    access(1'b1, 1'b0, 32'd5, 32'hDEADBEEF, lat, bn, rd, e);
    check("wr5_lat", 32'(lat), 32'd3);
    check("wr5_busy", 32'(bn), 32'd3);
    check("wr5_err", 32'(e), 32'd0);
    check("wr5_mem", u_dut.mem[5], 32'hDEADBEEF);

    access(1'b0, 1'b1, 32'd5, 32'h0, lat, bn, rd, e);
    check("rd5_lat", 32'(lat), 32'd3);
    check("rd5_dout", rd, 32'hDEADBEEF);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rd5_hold", dout, 32'hDEADBEEF);
    check("rd5_rdy_low", 32'(rdy), 32'h0);

    // Both strobes: write wins, DOUT untouched.
    access(1'b1, 1'b1, 32'd7, 32'h12345678, lat, bn, rd, e);
    check("both_lat", 32'(lat), 32'd3);
    check("both_dout", dout, 32'hDEADBEEF);
    access(1'b0, 1'b1, 32'd7, 32'h0, lat, bn, rd, e);
    check("rd7_dout", rd, 32'h12345678);

    // Reset during WAIT discards the pending write.
    access(1'b1, 1'b0, 32'd9, 32'h11111111, lat, bn, rd, e);
    ws = 1'b1; addr = 32'd9; din = 32'hCAFEF00D;
    @(posedge clk); @(negedge clk);
    check("rw_busy", 32'(busy), 32'h1);
    rst = 1'b1; ws = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("rw_state", 32'(u_dut.state_q), 32'h0);
    check("rw_busy_off", 32'(busy), 32'h0);
    rdy_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); @(negedge clk);
      if (rdy) rdy_seen++;
    end
    check("rw_no_rdy", 32'(rdy_seen), 32'h0);
    check("rw_mem9", u_dut.mem[9], 32'h11111111);
    access(1'b0, 1'b1, 32'd9, 32'h0, lat, bn, rd, e);
    check("rw_rd9", rd, 32'h11111111);

    // Out-of-range address 260 (wraps to 4 unless checking is enabled).
    access(1'b1, 1'b0, 32'd4, 32'h44444444, lat, bn, rd, e);
    access(1'b1, 1'b0, 32'd260, 32'hA5A5A5A5, lat, bn, rd, e);
    check("wr260_lat", 32'(lat), 32'd3);
`ifdef MEM_ADDR_CHECK_EN
    check("wr260_err", 32'(e), 32'd1);
    access(1'b0, 1'b1, 32'd4, 32'h0, lat, bn, rd, e);
    check("rd4_dout", rd, 32'h44444444);
    check("rd4_err", 32'(e), 32'd0);
    access(1'b0, 1'b1, 32'd260, 32'h0, lat, bn, rd, e);
    check("rd260_dout", rd, 32'h0);
    check("rd260_err", 32'(e), 32'd1);
`else
    check("wr260_err", 32'(e), 32'd0);
    access(1'b0, 1'b1, 32'd4, 32'h0, lat, bn, rd, e);
    check("rd4_dout", rd, 32'hA5A5A5A5);
    check("rd4_err", 32'(e), 32'd0);
`endif

    // Zero-wait-state instance: seed mem[3], then hold MEM_OE for 8 cycles.
    ws0 = 1'b1; addr = 32'd3; din = 32'h33333333;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ws0 = 1'b0;
    @(posedge clk); @(negedge clk);
    oe0 = 1'b1; n = 0; first = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); @(negedge clk);
      if (rdy0) begin
        n++;
        if (first < 0) begin
          first = k - 1;
          check("z_dout", dout0, 32'h33333333);
        end
      end
    end
    check("z_pulses", 32'(n), 32'd1);
    check("z_first", 32'(first), 32'd1);
    oe0 = 1'b0;
    @(posedge clk); @(negedge clk);
    oe0 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("z_reissue", 32'(rdy0), 32'd1);
    oe0 = 1'b0;
    @(posedge clk); @(negedge clk);

    // Reset coinciding with the DONE edge: no write, no RDY.
    ws0 = 1'b1; addr = 32'd3; din = 32'hBADBAD00;
    @(posedge clk); @(negedge clk);
    rst = 1'b1; ws0 = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("zr_rdy", 32'(rdy0), 32'd0);
    oe0 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("zr_rdy_rd", 32'(rdy0), 32'd1);
    check("zr_dout", dout0, 32'h33333333);
    oe0 = 1'b0;
    @(posedge clk); @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
